// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI target: FSM encoding and byte/bit-counter widths.
package spi_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      ACTIVE     = 2'd1,
      WAIT_DESEL = 2'd2
   } spi_state_t;

   localparam int C_BYTE_W = 8;
   localparam int C_CNT_W  = 3;

   localparam logic [C_CNT_W-1:0] C_LAST_BIT = '1;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchroniser for one SPI pin, followed by an edge-detect flop that yields
// single-cycle rise/fall pulses aligned with the synchronised level.
module spi_sync #(
   parameter int   C_STAGES  = 2,
   parameter logic C_RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic pin,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [C_STAGES-1:0] sync_reg;
   logic                prev_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_reg <= {C_STAGES{C_RST_VAL}};
         prev_reg <= C_RST_VAL;
      end else begin
         sync_reg <= {sync_reg[C_STAGES-2:0], pin};
         prev_reg <= sync_reg[C_STAGES-1];
      end
   end

   assign level = sync_reg[C_STAGES-1];
   assign rise  = level & ~prev_reg;
   assign fall  = ~level & prev_reg;

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target: oversamples the bus with clk, deserialises command bytes onto an rx
// valid/ready stream and serialises tx stream bytes onto the data pin, MSB first.
module spi_target
   import spi_pkg::*;
#(
   parameter logic [7:0] C_IDLE_BYTE   = 8'hFF,
   parameter int         C_SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       spi_clk_in,
   input  logic       spi_sel_in,
   input  logic       spi_cmd_in,
   output logic       spi_dat_out,
   output logic       spi_dat_oe,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       sel_active,
   output logic       frame_end,
   output logic       rx_overrun,
   output logic       tx_underrun,
   input  logic       clr_err
);

   logic sclk_level, sclk_rise, sclk_fall;
   logic sel_level, sel_rise, sel_fall;
   logic cmd_level;
   logic [1:0] cmd_edge_unused;
   logic sclk_level_unused;

   spi_sync #(.C_STAGES(C_SYNC_STAGES), .C_RST_VAL(1'b0)) u_sync_clk (
      .clk(clk), .rst(rst), .pin(spi_clk_in),
      .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
   );

   spi_sync #(.C_STAGES(C_SYNC_STAGES), .C_RST_VAL(1'b1)) u_sync_sel (
      .clk(clk), .rst(rst), .pin(spi_sel_in),
      .level(sel_level), .rise(sel_rise), .fall(sel_fall)
   );

   spi_sync #(.C_STAGES(C_SYNC_STAGES), .C_RST_VAL(1'b0)) u_sync_cmd (
      .clk(clk), .rst(rst), .pin(spi_cmd_in),
      .level(cmd_level), .rise(cmd_edge_unused[1]), .fall(cmd_edge_unused[0])
   );

   assign sclk_level_unused = sclk_level;

   spi_state_t            state_reg;
   logic [C_CNT_W-1:0]    bit_cnt_reg;
   logic [C_BYTE_W-2:0]   rx_shift_reg;
   logic [C_BYTE_W-2:0]   tx_shift_reg;
   logic                  dat_out_reg;
   logic                  dat_oe_reg;
   logic                  sel_active_reg;
   logic                  frame_end_reg;
   logic                  underrun_reg;
   logic                  overrun_reg;
   logic [C_BYTE_W-1:0]   rx_data_reg;
   logic                  rx_valid_reg;
   // Fills with ones after reset; until the MSB is set the sel chain may still hold its
   // reset value, so a sel fall seen then means the pin was already low mid-frame.
   logic [C_SYNC_STAGES:0] settle_reg;
   logic                  settled;

   logic                  start_frame;
   logic                  in_frame;
   logic                  load_event;
   logic [C_BYTE_W-1:0]   load_byte;
   logic                  byte_done;
   logic [C_BYTE_W-1:0]   byte_val;

   assign settled     = settle_reg[C_SYNC_STAGES];
   assign start_frame = (state_reg == IDLE) && sel_fall && settled;
   assign in_frame    = (state_reg == ACTIVE) && !sel_rise;
   assign load_event  = start_frame || (in_frame && sclk_fall && (bit_cnt_reg == '0));
   assign load_byte   = tx_valid ? tx_data : C_IDLE_BYTE;
   assign byte_done   = in_frame && sclk_rise && (bit_cnt_reg == C_LAST_BIT);
   assign byte_val    = {rx_shift_reg, cmd_level};

   assign tx_ready    = load_event && tx_valid && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         bit_cnt_reg    <= '0;
         rx_shift_reg   <= '0;
         tx_shift_reg   <= '1;
         dat_out_reg    <= 1'b1;
         dat_oe_reg     <= 1'b0;
         sel_active_reg <= 1'b0;
         frame_end_reg  <= 1'b0;
         underrun_reg   <= 1'b0;
         settle_reg     <= '0;
      end else begin
         settle_reg    <= {settle_reg[C_SYNC_STAGES-1:0], 1'b1};
         frame_end_reg <= 1'b0;

         if (clr_err)
            underrun_reg <= 1'b0;
         if (load_event && !tx_valid)
            underrun_reg <= 1'b1;

         unique case (state_reg)
            IDLE: begin
               if (sel_fall) begin
                  if (settled) begin
                     state_reg      <= ACTIVE;
                     bit_cnt_reg    <= '0;
                     tx_shift_reg   <= load_byte[C_BYTE_W-2:0];
                     dat_out_reg    <= load_byte[C_BYTE_W-1];
                     dat_oe_reg     <= 1'b1;
                     sel_active_reg <= 1'b1;
                  end else begin
                     state_reg <= WAIT_DESEL;
                  end
               end
            end
            ACTIVE: begin
               // Deselect takes priority over any sclk edge in the same cycle.
               if (sel_rise) begin
                  state_reg      <= IDLE;
                  bit_cnt_reg    <= '0;
                  frame_end_reg  <= 1'b1;
                  dat_out_reg    <= 1'b1;
                  dat_oe_reg     <= 1'b0;
                  sel_active_reg <= 1'b0;
               end else if (sclk_rise) begin
                  rx_shift_reg <= byte_val[C_BYTE_W-2:0];
                  bit_cnt_reg  <= bit_cnt_reg + 1'b1;
               end else if (sclk_fall) begin
                  if (bit_cnt_reg == '0) begin
                     tx_shift_reg <= load_byte[C_BYTE_W-2:0];
                     dat_out_reg  <= load_byte[C_BYTE_W-1];
                  end else begin
                     tx_shift_reg <= {tx_shift_reg[C_BYTE_W-3:0], 1'b1};
                     dat_out_reg  <= tx_shift_reg[C_BYTE_W-2];
                  end
               end
            end
            WAIT_DESEL: begin
               if (sel_level)
                  state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_data_reg  <= '0;
         rx_valid_reg <= 1'b0;
         overrun_reg  <= 1'b0;
      end else begin
         if (clr_err)
            overrun_reg <= 1'b0;
         if (byte_done) begin
            if (!rx_valid_reg || rx_ready) begin
               rx_data_reg  <= byte_val;
               rx_valid_reg <= 1'b1;
            end else begin
               overrun_reg <= 1'b1;
            end
         end else if (rx_valid_reg && rx_ready) begin
            rx_valid_reg <= 1'b0;
         end
      end
   end

   assign spi_dat_out = dat_out_reg;
   assign spi_dat_oe  = dat_oe_reg;
   assign rx_data     = rx_data_reg;
   assign rx_valid    = rx_valid_reg;
   assign sel_active  = sel_active_reg;
   assign frame_end   = frame_end_reg;
   assign rx_overrun  = overrun_reg;
   assign tx_underrun = underrun_reg;

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: drives the SPI pins at clk/16 and checks streams and flags.
module tb_spi_target;

   logic       clk = 1'b0;
   logic       rst;
   logic       spi_clk_in, spi_sel_in, spi_cmd_in;
   logic       spi_dat_out, spi_dat_oe;
   logic [7:0] rx_data;
   logic       rx_valid, rx_ready;
   logic [7:0] tx_data;
   logic       tx_valid, tx_ready;
   logic       sel_active, frame_end, rx_overrun, tx_underrun, clr_err;

   int tests = 0;
   int fails = 0;
   int txr_cnt = 0;
   int fe_cnt = 0;
   logic [7:0] rx_q[$];

   spi_target dut (
      .clk(clk), .rst(rst),
      .spi_clk_in(spi_clk_in), .spi_sel_in(spi_sel_in), .spi_cmd_in(spi_cmd_in),
      .spi_dat_out(spi_dat_out), .spi_dat_oe(spi_dat_oe),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .sel_active(sel_active), .frame_end(frame_end),
      .rx_overrun(rx_overrun), .tx_underrun(tx_underrun), .clr_err(clr_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (tx_ready) txr_cnt++;
      if (frame_end) fe_cnt++;
      if (rx_valid && rx_ready) rx_q.push_back(rx_data);
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Sends the top n bits of b (MSB first), capturing spi_dat_out at each sclk rise.
   task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] r);
      r = 8'h00;
      for (int i = 0; i < n; i++) begin
         spi_cmd_in = b[7-i];
         tick(8);
         spi_clk_in = 1'b1;
         r[7-i] = spi_dat_out;
         tick(8);
         spi_clk_in = 1'b0;
      end
   endtask

   task automatic consume_rx();
      rx_ready = 1'b1;
      tick(2);
      rx_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; spi_clk_in = 1'b0; spi_sel_in = 1'b1; spi_cmd_in = 1'b0;
      rx_ready = 1'b0; tx_data = 8'h00; tx_valid = 1'b0; clr_err = 1'b0;
      tick(4);
      tests++; if (spi_dat_out !== 1'b1) begin fails++; $display("FAIL reset_dat_out: got %b expected 1", spi_dat_out); end
      tests++; if (spi_dat_oe !== 1'b0) begin fails++; $display("FAIL reset_dat_oe: got %b expected 0", spi_dat_oe); end
      tests++; if (rx_data !== 8'h00) begin fails++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
      tests++; if ({rx_valid, tx_ready, sel_active, frame_end} !== 4'b0000) begin fails++; $display("FAIL reset_ctrl: got %b expected 0000", {rx_valid, tx_ready, sel_active, frame_end}); end
      tests++; if ({rx_overrun, tx_underrun} !== 2'b00) begin fails++; $display("FAIL reset_flags: got %b expected 00", {rx_overrun, tx_underrun}); end
      rst = 1'b0;
      tick(10);
      $display("[TB] reset done");
   endtask

   task automatic test_basic();
      logic [7:0] r, rl;
      tx_data = 8'h3C; tx_valid = 1'b1; rx_ready = 1'b0;
      txr_cnt = 0; fe_cnt = 0;
      spi_sel_in = 1'b0;
      tick(8);
      tests++; if ({sel_active, spi_dat_oe} !== 2'b11) begin fails++; $display("FAIL basic_active: got %b expected 11", {sel_active, spi_dat_oe}); end
      tests++; if (txr_cnt !== 1) begin fails++; $display("FAIL basic_txready_selfall: got %0d expected 1", txr_cnt); end
      spi_bits(8'hA5, 7, r);
      spi_cmd_in = 1'b1;
      tick(8);
      spi_clk_in = 1'b1;
      r[0] = spi_dat_out;
      tick(8);
      tests++; if (rx_valid !== 1'b1 || rx_data !== 8'hA5) begin fails++; $display("FAIL basic_rx: got v=%b d=%h expected v=1 d=a5", rx_valid, rx_data); end
      tests++; if (r !== 8'h3C) begin fails++; $display("FAIL basic_tx_bits: got %h expected 3c", r); end
      tests++; if (txr_cnt !== 1) begin fails++; $display("FAIL basic_txready_single: got %0d expected 1", txr_cnt); end
      spi_clk_in = 1'b0;
      tick(8);
      tests++; if (txr_cnt !== 2) begin fails++; $display("FAIL basic_txready_boundary: got %0d expected 2", txr_cnt); end
      tx_valid = 1'b0;
      spi_sel_in = 1'b1;
      tick(8);
      tests++; if (fe_cnt !== 1 || spi_dat_oe !== 1'b0 || sel_active !== 1'b0) begin fails++; $display("FAIL basic_end: got fe=%0d oe=%b act=%b expected fe=1 oe=0 act=0", fe_cnt, spi_dat_oe, sel_active); end
      tests++; if (tx_underrun !== 1'b0) begin fails++; $display("FAIL basic_no_underrun: got %b expected 0", tx_underrun); end
      consume_rx();
      tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL basic_consume: got %b expected 0", rx_valid); end
      rl = r;
      $display("[TB] basic frame: rx=a5 tx_bits=%h", rl);
   endtask

   task automatic test_underrun();
      logic [7:0] r;
      logic [7:0] exp_b [3] = '{8'h01, 8'h02, 8'h03};
      tx_valid = 1'b0; rx_ready = 1'b1; rx_q.delete();
      spi_sel_in = 1'b0;
      tick(8);
      for (int k = 0; k < 3; k++) begin
         spi_bits(exp_b[k], 8, r);
         tests++; if (r !== 8'hFF) begin fails++; $display("FAIL underrun_tx_byte%0d: got %h expected ff", k, r); end
      end
      spi_sel_in = 1'b1;
      tick(8);
      rx_ready = 1'b0;
      tests++; if (tx_underrun !== 1'b1) begin fails++; $display("FAIL underrun_flag: got %b expected 1", tx_underrun); end
      tests++; if (rx_q.size() !== 3) begin fails++; $display("FAIL underrun_rx_count: got %0d expected 3", rx_q.size()); end
      for (int k = 0; k < 3 && k < rx_q.size(); k++) begin
         tests++; if (rx_q[k] !== exp_b[k]) begin fails++; $display("FAIL underrun_rx_byte%0d: got %h expected %h", k, rx_q[k], exp_b[k]); end
      end
      tests++; if (rx_overrun !== 1'b0) begin fails++; $display("FAIL underrun_no_overrun: got %b expected 0", rx_overrun); end
      clr_err = 1'b1; tick(1); clr_err = 1'b0;
      tests++; if (tx_underrun !== 1'b0) begin fails++; $display("FAIL underrun_clear: got %b expected 0", tx_underrun); end
      $display("[TB] underrun frame: 3 bytes received");
   endtask

   task automatic test_overrun();
      logic [7:0] r;
      rx_ready = 1'b0; tx_valid = 1'b0;
      spi_sel_in = 1'b0;
      tick(8);
      spi_bits(8'h11, 8, r);
      spi_bits(8'h22, 8, r);
      spi_sel_in = 1'b1;
      tick(8);
      tests++; if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin fails++; $display("FAIL overrun_keep: got v=%b d=%h expected v=1 d=11", rx_valid, rx_data); end
      tests++; if (rx_overrun !== 1'b1) begin fails++; $display("FAIL overrun_flag: got %b expected 1", rx_overrun); end
      clr_err = 1'b1; tick(1); clr_err = 1'b0;
      tests++; if ({rx_overrun, tx_underrun} !== 2'b00) begin fails++; $display("FAIL overrun_clear: got %b expected 00", {rx_overrun, tx_underrun}); end
      consume_rx();
      $display("[TB] overrun frame: held 11");
   endtask

   task automatic test_abort();
      logic [7:0] r;
      rx_ready = 1'b0; fe_cnt = 0;
      spi_sel_in = 1'b0;
      tick(8);
      spi_bits(8'hF0, 5, r);
      spi_sel_in = 1'b1;
      tick(8);
      tests++; if (fe_cnt !== 1) begin fails++; $display("FAIL abort_frame_end: got %0d expected 1", fe_cnt); end
      tests++; if (rx_valid !== 1'b0 || spi_dat_oe !== 1'b0) begin fails++; $display("FAIL abort_state: got v=%b oe=%b expected v=0 oe=0", rx_valid, spi_dat_oe); end
      spi_sel_in = 1'b0;
      tick(8);
      spi_bits(8'h7E, 8, r);
      spi_sel_in = 1'b1;
      tick(8);
      tests++; if (rx_valid !== 1'b1 || rx_data !== 8'h7E) begin fails++; $display("FAIL abort_next_byte: got v=%b d=%h expected v=1 d=7e", rx_valid, rx_data); end
      consume_rx();
      $display("[TB] abort frame: next byte 7e");
   endtask

   task automatic test_reset_mid();
      logic [7:0] r;
      rx_ready = 1'b0;
      spi_sel_in = 1'b0;
      tick(8);
      spi_bits(8'hC3, 5, r);
      rst = 1'b1; tick(2); rst = 1'b0;
      spi_bits(8'hFF, 4, r);
      tick(8);
      tests++; if (rx_valid !== 1'b0 || spi_dat_oe !== 1'b0 || sel_active !== 1'b0) begin fails++; $display("FAIL rstmid_wait: got v=%b oe=%b act=%b expected 000", rx_valid, spi_dat_oe, sel_active); end
      spi_sel_in = 1'b1; tick(8);
      spi_sel_in = 1'b0; tick(8);
      tests++; if (sel_active !== 1'b1) begin fails++; $display("FAIL rstmid_reenter: got %b expected 1", sel_active); end
      spi_bits(8'h5A, 8, r);
      spi_sel_in = 1'b1; tick(8);
      tests++; if (rx_valid !== 1'b1 || rx_data !== 8'h5A) begin fails++; $display("FAIL rstmid_byte: got v=%b d=%h expected v=1 d=5a", rx_valid, rx_data); end
      consume_rx();
      clr_err = 1'b1; tick(1); clr_err = 1'b0;
      $display("[TB] reset mid-frame: recovered 5a");
   endtask

   task automatic test_coincident();
      logic [7:0] r;
      rx_ready = 1'b0; fe_cnt = 0;
      spi_sel_in = 1'b0;
      tick(8);
      spi_bits(8'hAB, 7, r);
      spi_cmd_in = 1'b1;
      tick(8);
      spi_clk_in = 1'b1;
      spi_sel_in = 1'b1;
      tick(8);
      tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL coinc_no_rx: got %b expected 0", rx_valid); end
      tests++; if (fe_cnt !== 1 || sel_active !== 1'b0) begin fails++; $display("FAIL coinc_idle: got fe=%0d act=%b expected fe=1 act=0", fe_cnt, sel_active); end
      spi_clk_in = 1'b0;
      tick(8);
      $display("[TB] coincident sel/sclk: sel wins");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_underrun();
      test_overrun();
      test_abort();
      test_reset_mid();
      test_coincident();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
